// File: rtl/bcd_to_bin.sv
// Packed-BCD to unsigned binary converter.
// One digit per clock, most significant digit first.
module bcd_to_bin #(
   parameter int DIGITS = 4,
   parameter int N      = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic [N-1:0]          binary,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic {
      IDLE,
      CONV
   } state_t;

   state_t              state;
   logic [4*DIGITS-1:0] cap;
   logic [N-1:0]        acc;
   logic [N-1:0]        acc_nxt;
   logic [IW-1:0]       idx;
   logic [3:0]          digit;
   logic                bad;

   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_in[4*i +: 4] > 4'd9) begin
            bad = 1'b1;
         end
      end
   end

   // acc*10 as shift-and-add, kept at N bits
   always_comb begin
      digit   = cap[{idx, 2'b00} +: 4];
      acc_nxt = (acc << 3) + (acc << 1) + {{(N-4){1'b0}}, digit};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cap    <= '0;
         acc    <= '0;
         idx    <= '0;
         binary <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         error  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start && bad) begin
                  error  <= 1'b1;
                  binary <= '0;
                  done   <= 1'b1;
               end else if (start) begin
                  cap   <= bcd_in;
                  acc   <= '0;
                  idx   <= IW'(DIGITS - 1);
                  error <= 1'b0;
                  busy  <= 1'b1;
                  state <= CONV;
               end
            end
            CONV: begin
               acc <= acc_nxt;
               idx <= idx - 1'b1;
               if (idx == '0) begin
                  binary <= acc_nxt;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Bench for bcd_to_bin: directed and random conversions,
// expected results queued and checked on every done pulse.
module tb_bcd_to_bin;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] bcd_in;
   logic [13:0] binary;
   logic        busy;
   logic        done;
   logic        error;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int   value;
      logic err;
   } exp_t;

   exp_t exp_q[$];

   bcd_to_bin #(.DIGITS(4), .N(14)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .bcd_in (bcd_in),
      .binary (binary),
      .busy   (busy),
      .done   (done),
      .error  (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst && done) begin
         exp_t e;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1, expected no pulse");
         end else begin
            e = exp_q.pop_front();
            check("sb_binary", int'(binary), e.value);
            check("sb_error", int'(error), int'(e.err));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [15:0] b, input int v, input logic e);
      exp_t x;
      x.value = v;
      x.err   = e;
      exp_q.push_back(x);
      start  = 1'b1;
      bcd_in = b;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      while (!done && k < 20) begin
         tick();
         k++;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: got no done, expected done within 20 cycles", name);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r[15:12] = 4'((v / 1000) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

   initial begin
      int v;
      rst    = 1'b0;
      start  = 1'b0;
      bcd_in = '0;
      repeat (3) tick();
      check("rst_binary", int'(binary), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_error", int'(error), 0);
      rst = 1'b1;
      repeat (2) tick();

      // latency and busy profile
      issue(16'h1234, 1234, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("lat_busy", int'(busy), 1);
         check("lat_done", int'(done), 0);
         tick();
      end
      check("lat_done_edge", int'(done), 1);
      check("lat_busy_end", int'(busy), 0);
      tick();
      check("done_one_cycle", int'(done), 0);

      issue(16'h0000, 0, 1'b0);
      wait_done("bnd_0000");
      tick();
      issue(16'h9999, 9999, 1'b0);
      wait_done("bnd_9999");
      tick();

      // invalid nibble
      issue(16'h12A4, 0, 1'b1);
      check("err_done", int'(done), 1);
      check("err_busy", int'(busy), 0);
      tick();
      issue(16'h0042, 42, 1'b0);
      wait_done("after_err");
      tick();

      // mid-conversion input changes, then start held at done
      issue(16'h0500, 500, 1'b0);
      start  = 1'b1;
      bcd_in = 16'h0777;
      repeat (2) tick();
      start = 1'b0;
      wait_done("hold_0500");
      issue(16'h0321, 321, 1'b0);
      check("b2b_busy", int'(busy), 1);
      wait_done("b2b_0321");
      tick();

      // reset mid-conversion
      start  = 1'b1;
      bcd_in = 16'h8888;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      check("abort_binary", int'(binary), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_error", int'(error), 0);
      repeat (6) tick();
      rst = 1'b1;
      repeat (2) tick();
      issue(16'h0007, 7, 1'b0);
      wait_done("post_rst");
      tick();

      for (int i = 0; i < 10; i++) begin
         v = int'($urandom_range(0, 9999));
         issue(to_bcd(v), v, 1'b0);
         wait_done("random");
         tick();
      end

      repeat (8) tick();
      check("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
